match_sequencer: RTL and testbench
==================================

# match_sequencer

Parametrised frame sequencer for the template-matching datapath. It steps through NUM_SETS sets per frame. For each set it drives the template handler, then the window handler, through the shared memory port. It then waits for the NCC result and writes it back as RES_WORDS 32-bit words under a memory-grant handshake. It adds abort, grant back-pressure, explicit result-valid wait and an optional watchdog.

## Interface
Parameters:
- NUM_SETS, 150, sets per frame; must be ≥ 1.
- RES_WORDS, 3, 32-bit words written back per set.
- NCC_W, 64, width of the NCC result.
- IDX_W, 13, width of the best-window index.
- ADDR_W, 7, row/col width.
- TIMEOUT_CYC, 4096, watchdog limit (used only with the macro).
- Derived: CNT_W = $clog2(NUM_SETS+1), WI_W = max(1,$clog2(RES_WORDS)).
- Elaboration error if NCC_W+IDX_W > 32*RES_WORDS.

Ports:
- clk, in, 1, sole clock.
- rst, in, 1, reset: asynchronous, active-high.
- start, in, 1, level; begin a frame when idle.
- abort, in, 1, level; cancel the frame.
- tmpl_en, out, 1, template handler enable.
- tmpl_row / tmpl_col, in, ADDR_W each, template handler address.
- tmpl_done, in, 1, template handler finished.
- win_en, out, 1, window handler enable.
- win_row / win_col, in, ADDR_W each, window handler address.
- win_done, in, 1, window handler finished.
- res_valid, in, 1, NCC result valid.
- res_ncc, in, NCC_W, NCC result value.
- res_idx, in, IDX_W, best-window index.
- mem_req, out, 1, memory request.
- mem_gnt, in, 1, memory grant.
- mem_rd_wr, out, 1, 0=read, 1=write.
- mem_tem_win, out, 1, 0=template, 1=window.
- mem_row / mem_col, out, ADDR_W each, memory address.
- mem_wdata, out, 32, write data.
- mem_wr_index, out, WI_W, index of the word being written.
- set_count, out, CNT_W, sets completed in the current frame.
- set_done, out, 1, one-cycle end-of-frame pulse.
- busy, out, 1, high in every state except IDLE.
- timeout_err, out, 1, sticky watchdog flag.

## Operation
States: IDLE, TEMP, WIND, WAIT_RES, WRITE, DONE, plus ERR when the macro is defined. All outputs are decoded from registered state (Moore), except that mem_row/mem_col mux combinationally from the handler inputs.
- IDLE: set_count held at 0. If start=1 and abort=0, go to TEMP.
- TEMP: tmpl_en=1, mem_req=1, mem_rd_wr=0, mem_tem_win=0, mem_row/col=tmpl_row/col. On tmpl_done, go to WIND.
- WIND: win_en=1, mem_req=1, mem_tem_win=1, mem_row/col=win_row/col. On win_done:
  - if res_valid is also high that cycle, latch the result and go to WRITE;
  - otherwise go to WAIT_RES.
- WAIT_RES: all enables low. On res_valid, latch the result and go to WRITE.
- Result packing: P = {res_ncc, res_idx, zero pad}, total width 32*RES_WORDS. Word k = P[32k+31:32k].
- WRITE: mem_req=1, mem_rd_wr=1, mem_wr_index=k, mem_wdata=word k, with k starting at 0.
  - k advances only on a cycle with mem_gnt=1.
  - When word RES_WORDS-1 is granted, set_count increments. If the pre-increment count was NUM_SETS-1, go to DONE; otherwise go to TEMP.
- DONE: set_done=1 for one cycle, set_count cleared, then go to IDLE.
- Abort: from any non-IDLE state, go to IDLE next cycle and clear set_count and k. No set_done. Abort beats every other event in the same cycle, including tmpl_done, win_done, res_valid and the last grant. Abort while in IDLE blocks start.
- A res_valid that arrives outside WIND/WAIT_RES is ignored.
- set_count never wraps: it saturates at NUM_SETS only transiently, before DONE clears it.

## Timing
- Reset values:
  - state IDLE; every output 0; set_count 0; result register 0; k 0; timeout_err 0.
  - mem_row/col follow their mux: 0 in IDLE.
- start sampled at edge N gives tmpl_en=1 and mem_req=1 during cycle N+1.
- One handler-done event gives the next state one cycle later.
- WRITE with mem_gnt held high takes RES_WORDS cycles. Each cycle of mem_gnt=0 adds one cycle, with outputs held stable.
- set_done is high exactly one cycle, the cycle after the final grant of set NUM_SETS-1.
- Reset asserted mid-frame forces all registers to their reset values immediately (asynchronous).

## Configuration
MATCH_SEQ_TIMEOUT_EN:
- Defined:
  - A cycle counter clears on every state change. It counts while in TEMP, WIND, WAIT_RES, or in WRITE with mem_gnt=0.
  - Reaching TIMEOUT_CYC moves to ERR. In ERR, all enables and mem_req are 0, busy=1, timeout_err=1.
  - ERR is left only via abort (to IDLE, clearing timeout_err) or via reset.
- Undefined: no counter, no ERR state, timeout_err tied to 0.

## Structure
- Package match_seq_pkg holds:
  - the state enum;
  - RD/WR and TEMPLATE/WINDOW select constants;
  - a function returning word k of the packed result.
- One sub-module, match_seq_counter: parametric width, clear/enable counter. Used for set_count and the watchdog.

## Test plan
- NUM_SETS=2, RES_WORDS=3, mem_gnt tied 1, handlers finish after 5 cycles, res_valid concurrent with win_done → exactly 6 write beats with mem_wr_index 0,1,2,0,1,2; set_done pulses once; set_count reads 1 then returns to 0.
- res_ncc=64'h0123_4567_89AB_CDEF, res_idx=13'h1ABC → word0={13'h1ABC's low bits at [31:19],19'b0}, word1=32'h89ABCDEF, word2=32'h01234567.
- mem_gnt low for 4 cycles during word 1 → mem_wdata and mem_wr_index held for those 4 cycles; WRITE lasts 7 cycles.
- res_valid arrives 10 cycles after win_done → FSM sits in WAIT_RES with mem_req=0, then WRITE begins the next cycle.
- abort in the same cycle as the final grant of the last set → IDLE, no set_done, set_count=0.
- With MATCH_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, tmpl_done never arrives → timeout_err=1 sixteen cycles after TEMP entry; abort then clears it.

Source files
------------

// File: rtl/match_seq_pkg.sv
// Shared types, select constants and result-word helper for the match sequencer.
package match_seq_pkg;

  // Upper bound on the packed result width handled by res_word().
  localparam int unsigned RES_MAX_BITS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TEMP     = 3'd1,
    ST_WIND     = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

  localparam logic MEM_RD       = 1'b0;
  localparam logic MEM_WR       = 1'b1;
  localparam logic SEL_TEMPLATE = 1'b0;
  localparam logic SEL_WINDOW   = 1'b1;

  // Word k (32 bits) of a packed result, word 0 at the LSBs.
  function automatic logic [31:0] res_word(input logic [RES_MAX_BITS-1:0] res,
                                           input int unsigned k);
    logic [RES_MAX_BITS-1:0] sh;
    sh = res >> (32 * k);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/match_seq_counter.sv
// Clear/enable up-counter; clear has priority over enable.
module match_seq_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/match_sequencer.sv
// Frame sequencer: template fetch, window fetch, NCC result wait, result write-back.
// Optional watchdog with ERR state enabled by defining MATCH_SEQ_TIMEOUT_EN.
module match_sequencer
  import match_seq_pkg::*;
#(
  parameter  int unsigned NUM_SETS    = 150,
  parameter  int unsigned RES_WORDS   = 3,
  parameter  int unsigned NCC_W       = 64,
  parameter  int unsigned IDX_W       = 13,
  parameter  int unsigned ADDR_W      = 7,
  parameter  int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned CNT_W       = $clog2(NUM_SETS + 1),
  localparam int unsigned WI_W        = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              tmpl_en,
  input  logic [ADDR_W-1:0] tmpl_row,
  input  logic [ADDR_W-1:0] tmpl_col,
  input  logic              tmpl_done,
  output logic              win_en,
  input  logic [ADDR_W-1:0] win_row,
  input  logic [ADDR_W-1:0] win_col,
  input  logic              win_done,
  input  logic              res_valid,
  input  logic [NCC_W-1:0]  res_ncc,
  input  logic [IDX_W-1:0]  res_idx,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_rd_wr,
  output logic              mem_tem_win,
  output logic [ADDR_W-1:0] mem_row,
  output logic [ADDR_W-1:0] mem_col,
  output logic [31:0]       mem_wdata,
  output logic [WI_W-1:0]   mem_wr_index,
  output logic [CNT_W-1:0]  set_count,
  output logic              set_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned RES_BITS = 32 * RES_WORDS;
  localparam int unsigned PAD_W    = RES_BITS - NCC_W - IDX_W;

  if (NCC_W + IDX_W > RES_BITS) begin : g_bad_res_width
    $error("match_sequencer: NCC_W+IDX_W exceeds 32*RES_WORDS");
  end
  if (RES_BITS > RES_MAX_BITS) begin : g_bad_res_max
    $error("match_sequencer: RES_WORDS too large for res_word()");
  end
  if (NUM_SETS < 1 || TIMEOUT_CYC < 1) begin : g_bad_counts
    $error("match_sequencer: NUM_SETS and TIMEOUT_CYC must be >= 1");
  end

  state_e              state_q, state_d;
  logic [WI_W-1:0]     k_q, k_d;
  logic [RES_BITS-1:0] res_q, res_d;
  logic                set_inc, set_clr;
  logic [RES_BITS-1:0] res_packed;

  // Result layout: {ncc, idx, zero pad}, word 0 in the LSBs.
  assign res_packed = RES_BITS'({res_ncc, res_idx}) << PAD_W;

  // Sets completed in the current frame.
  match_seq_counter #(.W(CNT_W)) u_set_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (set_clr),
    .en_i  (set_inc),
    .cnt_o (set_count)
  );

`ifdef MATCH_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic            wd_en, wd_hit;
  logic [WD_W-1:0] wd_cnt;

  // Watchdog runs while waiting on a handler, the result or a grant.
  always_comb begin
    wd_en  = (state_q == ST_TEMP) || (state_q == ST_WIND) || (state_q == ST_WAIT_RES) ||
             ((state_q == ST_WRITE) && !mem_gnt);
    wd_hit = wd_en && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  end

  // Watchdog counter restarts on every state change.
  match_seq_counter #(.W(WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_d != state_q),
    .en_i  (wd_en),
    .cnt_o (wd_cnt)
  );
`endif

  // State, write-word index and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    res_d        = res_q;
    set_inc      = 1'b0;
    set_clr      = 1'b0;
    tmpl_en      = 1'b0;
    win_en       = 1'b0;
    mem_req      = 1'b0;
    mem_rd_wr    = MEM_RD;
    mem_tem_win  = SEL_TEMPLATE;
    mem_row      = '0;
    mem_col      = '0;
    mem_wdata    = '0;
    mem_wr_index = '0;
    set_done     = 1'b0;
    timeout_err  = 1'b0;
    busy         = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        set_clr = 1'b1;
        if (start && !abort) state_d = ST_TEMP;
      end
      ST_TEMP: begin
        tmpl_en     = 1'b1;
        mem_req     = 1'b1;
        mem_tem_win = SEL_TEMPLATE;
        mem_row     = tmpl_row;
        mem_col     = tmpl_col;
        if (tmpl_done) state_d = ST_WIND;
      end
      ST_WIND: begin
        win_en      = 1'b1;
        mem_req     = 1'b1;
        mem_tem_win = SEL_WINDOW;
        mem_row     = win_row;
        mem_col     = win_col;
        if (win_done) begin
          if (res_valid) begin
            res_d   = res_packed;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_WAIT_RES;
          end
        end
      end
      ST_WAIT_RES: begin
        if (res_valid) begin
          res_d   = res_packed;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_req      = 1'b1;
        mem_rd_wr    = MEM_WR;
        mem_wr_index = k_q;
        mem_wdata    = res_word(RES_MAX_BITS'(res_q), 32'(k_q));
        if (mem_gnt) begin
          if (k_q == WI_W'(RES_WORDS - 1)) begin
            k_d     = '0;
            set_inc = 1'b1;
            state_d = (set_count == CNT_W'(NUM_SETS - 1)) ? ST_DONE : ST_TEMP;
          end else begin
            k_d = k_q + WI_W'(1);
          end
        end
      end
      ST_DONE: begin
        set_done = 1'b1;
        set_clr  = 1'b1;
        state_d  = ST_IDLE;
      end
`ifdef MATCH_SEQ_TIMEOUT_EN
      ST_ERR: begin
        timeout_err = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef MATCH_SEQ_TIMEOUT_EN
    // A stalled wait escalates to ERR; only abort or reset leaves it.
    if (wd_hit) begin
      state_d = ST_ERR;
      k_d     = k_q;
      res_d   = res_q;
      set_inc = 1'b0;
    end
`endif

    // Abort outranks every other event in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      k_d     = '0;
      res_d   = res_q;
      set_inc = 1'b0;
      set_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer: directed frames, grant stalls, abort, reset, watchdog.
module tb_match_sequencer;

  localparam int unsigned NUM_SETS    = 2;
  localparam int unsigned RES_WORDS   = 3;
  localparam int unsigned NCC_W       = 64;
  localparam int unsigned IDX_W       = 13;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned WI_W        = 2;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic              tmpl_en, tmpl_done, win_en, win_done, res_valid;
  logic [ADDR_W-1:0] tmpl_row, tmpl_col, win_row, win_col, mem_row, mem_col;
  logic [NCC_W-1:0]  res_ncc;
  logic [IDX_W-1:0]  res_idx;
  logic              mem_req, mem_gnt, mem_rd_wr, mem_tem_win;
  logic [31:0]       mem_wdata;
  logic [WI_W-1:0]   mem_wr_index;
  logic [CNT_W-1:0]  set_count;
  logic              set_done, busy, timeout_err;

  typedef struct packed {
    logic [WI_W-1:0] idx;
    logic [31:0]     data;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    beats       = 0;
  int    done_pulses = 0;

  always #5 clk = ~clk;

  match_sequencer #(
    .NUM_SETS(NUM_SETS), .RES_WORDS(RES_WORDS), .NCC_W(NCC_W), .IDX_W(IDX_W),
    .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tmpl_en(tmpl_en), .tmpl_row(tmpl_row), .tmpl_col(tmpl_col), .tmpl_done(tmpl_done),
    .win_en(win_en), .win_row(win_row), .win_col(win_col), .win_done(win_done),
    .res_valid(res_valid), .res_ncc(res_ncc), .res_idx(res_idx),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_rd_wr(mem_rd_wr), .mem_tem_win(mem_tem_win),
    .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_wr_index(mem_wr_index),
    .set_count(set_count), .set_done(set_done), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every granted write beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && mem_req && mem_rd_wr && mem_gnt) begin
      beats++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_unexpected: got idx %0d data %h, expected no beat", mem_wr_index, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("beat_index", 64'(mem_wr_index), 64'(e.idx));
        check("beat_data", 64'(mem_wdata), 64'(e.data));
      end
    end
    if (!rst && set_done) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One set: template, window, result, write-back with optional result delay, grant stall, abort.
  task automatic run_set(input logic [63:0] ncc, input logic [12:0] idx,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input int exp_count, input int res_delay,
                         input int stall_word, input int stall_len,
                         input bit last, input bit abort_last);
    logic [31:0] w[3];
    bit seen, ok, stall;
    int granted, stalled, wcyc, wr_cycles;
    w[0] = w0; w[1] = w1; w[2] = w2;

    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = tmpl_en;
    end
    check("temp_entry", 64'(seen), 64'd1);
    check("temp_port", 64'({mem_req, mem_rd_wr, mem_tem_win, win_en}), 64'b1000);
    check("temp_addr", 64'({mem_row, mem_col}), 64'({tmpl_row, tmpl_col}));
    check("temp_set_count", 64'(set_count), 64'(exp_count));
    repeat (4) @(posedge clk);
    #1 tmpl_done = 1'b1;
    @(posedge clk); #1 tmpl_done = 1'b0;

    @(negedge clk);
    check("wind_port", 64'({tmpl_en, win_en, mem_req, mem_tem_win, mem_rd_wr}), 64'b01110);
    check("wind_addr", 64'({mem_row, mem_col}), 64'({win_row, win_col}));
    repeat (4) @(posedge clk);
    #1 win_done = 1'b1;
    if (res_delay == 0) begin
      res_valid = 1'b1; res_ncc = ncc; res_idx = idx;
      for (int i = 0; i < 3; i++) exp_q.push_back(beat_t'{idx: WI_W'(i), data: w[i]});
    end
    @(posedge clk); #1 win_done = 1'b0; res_valid = 1'b0;

    if (res_delay > 0) begin
      ok = 1'b1;
      for (int n = 0; n < res_delay; n++) begin
        @(negedge clk);
        if (mem_req || win_en || tmpl_en || !busy) ok = 1'b0;
      end
      check("wait_res_quiet", 64'(ok), 64'd1);
      @(posedge clk); #1 res_valid = 1'b1; res_ncc = ncc; res_idx = idx;
      for (int i = 0; i < 3; i++) exp_q.push_back(beat_t'{idx: WI_W'(i), data: w[i]});
      @(posedge clk); #1 res_valid = 1'b0;
    end

    granted = 0; stalled = 0; wcyc = 0; wr_cycles = 0;
    while (granted < int'(RES_WORDS) && wcyc < 40) begin
      stall     = (granted == stall_word) && (stalled < stall_len);
      mem_gnt   = !stall;
      abort     = abort_last && !stall && (granted == int'(RES_WORDS) - 1);
      res_valid = stall;
      res_ncc   = stall ? 64'hBAD0_BAD0_BAD0_BAD0 : ncc;
      @(negedge clk);
      wcyc++;
      if (mem_req && mem_rd_wr) wr_cycles++;
      if (stall) begin
        check("stall_hold", 64'({mem_wr_index, mem_wdata}), 64'({2'(stall_word), w[stall_word]}));
        stalled++;
      end else begin
        granted++;
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1; abort = 1'b0; res_valid = 1'b0;
    check("write_cycles", 64'(wr_cycles), 64'(int'(RES_WORDS) + stall_len));

    @(negedge clk);
    if (abort_last) begin
      check("abort_final", 64'({busy, set_done, set_count}), 64'd0);
    end else if (last) begin
      check("frame_done", 64'({set_done, set_count}), 64'({1'b1, 2'(NUM_SETS)}));
      @(negedge clk);
      check("post_done", 64'({busy, set_done, set_count}), 64'd0);
    end else begin
      check("next_set", 64'({set_done, tmpl_en, set_count}), 64'({2'b01, 2'(exp_count + 1)}));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tmpl_done = 1'b0; win_done = 1'b0;
    res_valid = 1'b0; res_ncc = '0; res_idx = '0; mem_gnt = 1'b1;
    tmpl_row = 7'h11; tmpl_col = 7'h22; win_row = 7'h33; win_col = 7'h44;

    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({busy, tmpl_en, win_en, mem_req, mem_rd_wr, mem_tem_win, set_done, timeout_err}), 64'd0);
    check("reset_data", 64'({set_count, mem_wr_index, mem_wdata}), 64'd0);
    check("reset_addr", 64'({mem_row, mem_col}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: two plain sets, grant tied high.
    start_frame();
    run_set(64'h0123_4567_89AB_CDEF, 13'h1ABC, 32'hD5E0_0000, 32'h89AB_CDEF, 32'h0123_4567, 0, 0, -1, 0, 1'b0, 1'b0);
    run_set(64'hFFFF_0000_AAAA_5555, 13'h0001, 32'h0008_0000, 32'hAAAA_5555, 32'hFFFF_0000, 1, 0, -1, 0, 1'b1, 1'b0);
    check("f1_beats", 64'(beats), 64'd6);
    check("f1_done_pulses", 64'(done_pulses), 64'd1);

    // Frame 2: delayed result and a 4-cycle grant stall on word 1.
    start_frame();
    run_set(64'h0000_0000_0000_0001, 13'h1FFF, 32'hFFF8_0000, 32'h0000_0001, 32'h0000_0000, 0, 10, 1, 4, 1'b0, 1'b0);
    run_set(64'hDEAD_BEEF_CAFE_F00D, 13'h0AAA, 32'h5550_0000, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1, 0, -1, 0, 1'b1, 1'b0);
    check("f2_done_pulses", 64'(done_pulses), 64'd2);

    // Frame 3: abort coincides with the final grant of the last set.
    start_frame();
    run_set(64'h0123_4567_89AB_CDEF, 13'h1ABC, 32'hD5E0_0000, 32'h89AB_CDEF, 32'h0123_4567, 0, 0, -1, 0, 1'b0, 1'b0);
    run_set(64'hFFFF_0000_AAAA_5555, 13'h0001, 32'h0008_0000, 32'hAAAA_5555, 32'hFFFF_0000, 1, 0, -1, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("f3_no_done", 64'(done_pulses), 64'd2);
    check("f3_idle", 64'({busy, mem_req}), 64'd0);

    // Abort held in IDLE blocks start.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_blocks_start", 64'({busy, tmpl_en}), 64'd0);
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;

    // Asynchronous reset in the middle of a frame.
    start_frame();
    @(negedge clk);
    check("pre_reset_busy", 64'({busy, tmpl_en}), 64'b11);
    #2 rst = 1'b1;
    #1 check("async_reset", 64'({busy, tmpl_en, mem_req, mem_row, mem_col}), 64'd0);
    @(negedge clk); #2 rst = 1'b0;

`ifdef MATCH_SEQ_TIMEOUT_EN
    // Watchdog: template handler never finishes.
    start_frame();
    @(negedge clk);
    check("wd_temp_entry", 64'(tmpl_en), 64'd1);
    repeat (15) @(negedge clk);
    check("wd_not_yet", 64'(timeout_err), 64'd0);
    @(negedge clk);
    check("wd_fired", 64'({timeout_err, busy, mem_req, tmpl_en}), 64'b1100);
    repeat (3) @(negedge clk);
    check("wd_sticky", 64'({timeout_err, busy}), 64'b11);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("wd_cleared", 64'({timeout_err, busy}), 64'd0);
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
